mu0_mem_ctrl: RTL and testbench
===============================

// Module: mu0_mem_ctrl
// PURPOSE
//   Parametrised memory controller/model for the MU0 system; the next generation of
//   the fixed 12-bit/16-bit memory model. Accepts memrq/rnw requests from the core,
//   inserts a configurable number of wait states and returns a one-cycle ready strobe.
//   Uses split rdata/wdata buses, not a bidirectional data bus; the core or top level
//   instantiates any tri-state adaptor.
// PARAMETERS
//   ADDR_W       12    address width in bits
//   DATA_W       16    word width in bits
//   DEPTH        4096  number of words; power of two, <= 2**ADDR_W
//   WAIT_CYCLES  0     wait states inserted per access, 0..15
// PORTS
//   clk     in   1       clock; everything is sampled on its rising edge
//   reset   in   1       asynchronous, active-low reset (0 = reset asserted)
//   memrq   in   1       request valid
//   rnw     in   1       1 = read, 0 = write; sampled with memrq
//   addr    in   ADDR_W  word address; sampled with memrq
//   wdata   in   DATA_W  write data; sampled with memrq
//   rdata   out  DATA_W  read data; valid while ready=1 for a read
//   ready   out  1       one-cycle completion strobe
//   busy    out  1       1 while a request is in flight (state != IDLE)
//   err     out  1       range error, valid with ready (only when MEM_ERR_EN is defined)
// BEHAVIOUR
//   Reset values: state=IDLE, wait counter=0, rdata=0, ready=0, busy=0, err=0.
//   Memory contents are not reset.
//   FSM: IDLE -> (WAIT_CYCLES>0 ? WAIT : RESP) -> IDLE.
//   - IDLE: memrq=1 at a rising edge accepts the request. addr, rnw and wdata are
//     latched and the counter is loaded with WAIT_CYCLES.
//   - WAIT: counter decrements each cycle. When the counter reaches 1, the next edge
//     moves the FSM to RESP.
//   - RESP: ready=1 for exactly one cycle, then IDLE.
//   Latency: WAIT_CYCLES+1 cycles from the accept edge to the ready cycle.
//   Throughput: one access per WAIT_CYCLES+2 cycles.
//   Commit timing: on the edge entering RESP, a write updates the array and a read
//   loads rdata. rdata holds its value until the next read completes; writes leave it
//   unchanged.
//   memrq in WAIT/RESP is ignored and never queued; the requester re-presents it in IDLE.
//   addr/rnw/wdata changes after the accept edge have no effect.
//   Index = addr[$clog2(DEPTH)-1:0]. Upper address bits are handled by the range
//   rule under CONFIGURATION.
//   Reset asserted mid-access: FSM aborts to IDLE and outputs go to reset values.
//   An uncommitted write is dropped; a write already committed stays in the array.
//   Back-to-back write then read of the same address: the read returns the new data.
// CONFIGURATION
//   Macro MEM_ERR_EN:
//   - Defined: an access with addr >= DEPTH is out of range.
//     A write is suppressed; a read returns rdata=0.
//     err=1 in the RESP cycle, 0 otherwise. Timing is unchanged.
//   - Undefined: upper address bits are ignored, so addresses alias modulo DEPTH.
//     err is tied to 0.
// STRUCTURE
//   Package mu0_mem_pkg: state typedef/encoding (IDLE, WAIT, RESP) and the counter
//   width constant (4 bits).
//   Sub-module mu0_mem_array: synchronous single-port RAM with ports
//   clk, we, idx, wdata, rdata (registered read). No reset on the array.
//   Top level holds the FSM, the wait counter, the request latches and the range check.
// TESTING
//   1. WAIT_CYCLES=0: write 0x1234 @0x005, then read @0x005
//      -> ready 1 cycle after each accept; rdata=0x1234; busy high for 1 cycle.
//   2. WAIT_CYCLES=3: read @0x010 preloaded with 0xBEEF
//      -> ready exactly 4 cycles after accept; busy high 4 cycles; rdata=0xBEEF.
//   3. memrq held high continuously, WAIT_CYCLES=2
//      -> one access per 4 cycles; requests during WAIT/RESP are not double-counted.
//   4. Reset pulled low during WAIT of a write 0xAAAA @0x020
//      -> ready/busy/rdata=0 immediately; a later read @0x020 returns the old value.
//   5. DEPTH=256, write 0x5555 @0x105:
//      - MEM_ERR_EN defined -> err=1 with ready, @0x005 unchanged.
//      - MEM_ERR_EN undefined -> @0x005 reads 0x5555, err=0.
//   6. Change addr/wdata one cycle after accept, WAIT_CYCLES=2
//      -> the originally latched values are used.

Source files
------------

// File: rtl/mu0_mem_pkg.sv
// Shared types for the MU0 memory controller: FSM state encoding and wait-counter width.
package mu0_mem_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mu0_mem_array.sv
// Synchronous single-port RAM with registered read; storage is deliberately not reset.
module mu0_mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: no reset on the storage or its read register, so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        rdata_q <= mem_q[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mu0_mem_ctrl.sv
// MU0 memory controller: request FSM, wait-state counter, request latches, range check.
// Define MEM_ERR_EN to flag (and suppress) accesses with addr >= DEPTH; otherwise addresses alias.
module mu0_mem_ctrl
    import mu0_mem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memrq,
    input  logic              rnw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int   IDX_W     = $clog2(DEPTH);
    localparam cnt_t WAIT_INIT = cnt_t'(WAIT_CYCLES);

    state_e            state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic              rnw_q, rnw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              oor_q, oor_d;

    logic              oor_live;
    logic              commit;
    logic              c_rnw;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_oor;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;
    logic [DATA_W-1:0] resp_data;

`ifdef MEM_ERR_EN
    // DEPTH may equal 2**ADDR_W, so compare one bit wider to keep the bound representable.
    assign oor_live = ({1'b0, addr} >= (ADDR_W+1)'(DEPTH));
    assign err      = (state_q == ST_RESP) && oor_q;
`else
    assign oor_live = 1'b0;
    assign err      = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        commit  = 1'b0;
        c_rnw   = rnw_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_oor   = oor_q;

        unique case (state_q)
            ST_IDLE: begin
                if (memrq) begin
                    rnw_d   = rnw;
                    addr_d  = addr;
                    wdata_d = wdata;
                    oor_d   = oor_live;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_INIT == '0) begin
                        // With no wait states the accept edge is also the commit edge.
                        state_d = ST_RESP;
                        commit  = 1'b1;
                        c_rnw   = rnw;
                        c_addr  = addr;
                        c_wdata = wdata;
                        c_oor   = oor_live;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - cnt_t'(1);
                if (cnt_q == cnt_t'(1)) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (rnw_q) begin
                    rdata_d = resp_data;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign arr_we = commit && !c_rnw && !c_oor;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
        end
    end

    mu0_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (c_addr[IDX_W-1:0]),
        .wdata (c_wdata),
        .rdata (arr_rdata)
    );

    // The array's read register is live only in RESP; rdata_q holds it until the next read.
    assign resp_data = oor_q ? '0 : arr_rdata;
    assign rdata     = (state_q == ST_RESP && rnw_q) ? resp_data : rdata_q;
    assign ready     = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mu0_mem_ctrl.sv
// Scoreboard bench for mu0_mem_ctrl: three instances (0, 2 and 3 wait states; one with DEPTH=256).
module tb_mu0_mem_ctrl;

    typedef struct {
        int          cyc;
        bit          chk;
        logic [15:0] data;
        bit          err;
    } exp_t;

`ifdef MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int W_OF [3] = '{0, 2, 3};

    logic        clk = 1'b0;
    logic        reset;
    logic        memrq_s [3];
    logic        rnw_s   [3];
    logic [11:0] addr_s  [3];
    logic [15:0] wdata_s [3];
    logic [15:0] rdata_s [3];
    logic        ready_s [3];
    logic        busy_s  [3];
    logic        err_s   [3];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   busy_run [3] = '{0, 0, 0};
    exp_t sb [3][$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mu0_mem_ctrl #(.ADDR_W(12), .DATA_W(16), .DEPTH(4096), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .memrq(memrq_s[0]), .rnw(rnw_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .busy(busy_s[0]), .err(err_s[0])
    );
    mu0_mem_ctrl #(.ADDR_W(12), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(reset), .memrq(memrq_s[1]), .rnw(rnw_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .busy(busy_s[1]), .err(err_s[1])
    );
    mu0_mem_ctrl #(.ADDR_W(12), .DATA_W(16), .DEPTH(4096), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset), .memrq(memrq_s[2]), .rnw(rnw_s[2]), .addr(addr_s[2]),
        .wdata(wdata_s[2]), .rdata(rdata_s[2]), .ready(ready_s[2]), .busy(busy_s[2]), .err(err_s[2])
    );

    task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s unit%0d: got 0x%0h expected 0x%0h (t=%0t)", name, u, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per ready strobe and checks timing, data, err and busy span.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (busy_s[u]) busy_run[u] = busy_run[u] + 1;
            else           busy_run[u] = 0;
            if (ready_s[u]) begin
                if (sb[u].size() == 0) begin
                    check("unexpected_ready", u, 32'(ready_s[u]), 32'd0);
                end else begin
                    mon_e = sb[u].pop_front();
                    check("ready_cycle", u, 32'(cyc), 32'(mon_e.cyc));
                    check("busy_span", u, 32'(busy_run[u]), 32'(W_OF[u] + 1));
                    check("err", u, 32'(err_s[u]), 32'(mon_e.err));
                    if (mon_e.chk) check("rdata", u, 32'(rdata_s[u]), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic wait_idle(input int u);
        int n = 0;
        while (busy_s[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", u, 32'(busy_s[u]), 32'd0);
    endtask

    // Issue one access from a negedge with the unit idle; optionally disturb inputs after accept.
    task automatic access(input int u, input bit rd, input logic [11:0] a, input logic [15:0] d,
                          input logic [15:0] exp_d, input bit exp_e, input bit scramble);
        exp_t e;
        memrq_s[u] = 1'b1;
        rnw_s[u]   = rd;
        addr_s[u]  = a;
        wdata_s[u] = d;
        @(posedge clk);
        #1;
        e.cyc  = cyc + W_OF[u];
        e.chk  = rd;
        e.data = exp_d;
        e.err  = exp_e;
        sb[u].push_back(e);
        @(negedge clk);
        memrq_s[u] = 1'b0;
        if (scramble) begin
            addr_s[u]  = a ^ 12'h001;
            wdata_s[u] = ~d;
            rnw_s[u]   = ~rd;
        end
        wait_idle(u);
    endtask

    initial begin
        exp_t e;
        int   c;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   c;
        reset = 1'b0;
        for (int u = 0; u < 3; u++) begin
            memrq_s[u] = 1'b0;
            rnw_s[u]   = 1'b0;
            addr_s[u]  = '0;
            wdata_s[u] = '0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check("rst_ready", u, 32'(ready_s[u]), 32'd0);
            check("rst_busy",  u, 32'(busy_s[u]),  32'd0);
            check("rst_rdata", u, 32'(rdata_s[u]), 32'd0);
            check("rst_err",   u, 32'(err_s[u]),   32'd0);
        end
        reset = 1'b1;
        @(negedge clk);

        // Zero wait states: write then read back, rdata holds across a later write.
        access(0, 1'b0, 12'h005, 16'h1234, 16'h0000, 1'b0, 1'b0);
        access(0, 1'b1, 12'h005, 16'h0000, 16'h1234, 1'b0, 1'b0);
        access(0, 1'b0, 12'h006, 16'h4321, 16'h0000, 1'b0, 1'b0);
        check("rdata_hold", 0, 32'(rdata_s[0]), 32'h1234);

        // Three wait states: preload and read.
        access(2, 1'b0, 12'h010, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
        access(2, 1'b1, 12'h010, 16'h0000, 16'hBEEF, 1'b0, 1'b0);

        // DEPTH=256: upper address bits either flag an error or alias.
        access(1, 1'b0, 12'h005, 16'h7777, 16'h0000, 1'b0, 1'b0);
        access(1, 1'b0, 12'h105, 16'h5555, 16'h0000, ERR_EN, 1'b0);
        access(1, 1'b1, 12'h005, 16'h0000, ERR_EN ? 16'h7777 : 16'h5555, 1'b0, 1'b0);
        access(1, 1'b1, 12'h105, 16'h0000, ERR_EN ? 16'h0000 : 16'h5555, ERR_EN, 1'b0);

        // Inputs changed after accept must not affect the access.
        access(1, 1'b0, 12'h032, 16'h0101, 16'h0000, 1'b0, 1'b0);
        access(1, 1'b0, 12'h033, 16'h9999, 16'h0000, 1'b0, 1'b1);
        access(1, 1'b1, 12'h033, 16'h0000, 16'h9999, 1'b0, 1'b0);
        access(1, 1'b1, 12'h032, 16'h0000, 16'h0101, 1'b0, 1'b0);

        // memrq held high: accepts at c+1, c+5, c+9; ready two edges later each.
        access(1, 1'b0, 12'h040, 16'h4444, 16'h0000, 1'b0, 1'b0);
        c = cyc;
        for (int k = 0; k < 3; k++) begin
            e.cyc  = c + 3 + 4 * k;
            e.chk  = 1'b1;
            e.data = 16'h4444;
            e.err  = 1'b0;
            sb[1].push_back(e);
        end
        memrq_s[1] = 1'b1;
        rnw_s[1]   = 1'b1;
        addr_s[1]  = 12'h040;
        repeat (11) @(negedge clk);
        memrq_s[1] = 1'b0;
        wait_idle(1);

        // Reset during WAIT of a write: outputs clear at once, old data survives.
        access(2, 1'b0, 12'h020, 16'h1111, 16'h0000, 1'b0, 1'b0);
        access(2, 1'b1, 12'h020, 16'h0000, 16'h1111, 1'b0, 1'b0);
        memrq_s[2] = 1'b1;
        rnw_s[2]   = 1'b0;
        addr_s[2]  = 12'h020;
        wdata_s[2] = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        memrq_s[2] = 1'b0;
        @(negedge clk);
        check("pre_abort_busy", 2, 32'(busy_s[2]), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_ready", 2, 32'(ready_s[2]), 32'd0);
        check("abort_busy",  2, 32'(busy_s[2]),  32'd0);
        check("abort_rdata", 2, 32'(rdata_s[2]), 32'd0);
        check("abort_err",   2, 32'(err_s[2]),   32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        access(2, 1'b1, 12'h020, 16'h0000, 16'h1111, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check("sb_empty", u, 32'(sb[u].size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
